// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared state type, raster constants and LFSR step for the camera view controller
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    STATIC
  } cam_state_t;

  localparam int          H_TOTAL   = 800;
  localparam int          V_TOTAL   = 525;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois form: the bit shifted out folds back through the taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/static_lfsr.sv
// rtl/static_lfsr.sv - 16-bit Galois noise source that advances only while enabled
module static_lfsr
  import camera_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= LFSR_SEED;
    end else if (enable) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/camera_view_ctrl.sv
// rtl/camera_view_ctrl.sv - frame-aligned camera switching with a static transition (CAMERA_STATIC_FADE_EN fades the static)
module camera_view_ctrl
  import camera_pkg::*;
#(
  parameter int NUM_CAMS      = 4,
  parameter int CAM_IDW       = 3,
  parameter int STATIC_FRAMES = 4,
  parameter int DEFAULT_CAM   = 0
) (
  input  logic                        vga_clk,
  input  logic                        reset_n,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        blank,
  input  logic                        cam_req_valid,
  input  logic [CAM_IDW-1:0]          cam_req_id,
  output logic                        cam_req_ready,
  output logic                        req_err,
  output logic [$clog2(NUM_CAMS)-1:0] cam_sel,
  output logic                        static_en,
  output logic [3:0]                  static_level
);

  localparam int SELW = $clog2(NUM_CAMS);
  localparam int FCW  = $clog2(STATIC_FRAMES + 1);
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(STATIC_FRAMES - 1);

  cam_state_t      state;
  logic [SELW-1:0] pend_id;
  logic [FCW-1:0]  frame_cnt;
  logic [15:0]     lfsr_q;
  logic [3:0]      noise;
  logic            frame_start;
  logic            accept;
  logic            id_invalid;
  logic            id_same;
  logic            lfsr_unused;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign accept      = cam_req_valid && cam_req_ready;
  assign id_invalid  = int'(cam_req_id) >= NUM_CAMS;
  assign id_same     = int'(cam_req_id) == int'(cam_sel);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cam_sel       <= SELW'(DEFAULT_CAM);
      pend_id       <= '0;
      frame_cnt     <= '0;
      cam_req_ready <= 1'b1;
      req_err       <= 1'b0;
      static_en     <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (id_invalid) begin
              req_err <= 1'b1;
            end else if (!id_same) begin
              pend_id       <= cam_req_id[SELW-1:0];
              state         <= WAIT_FRAME;
              cam_req_ready <= 1'b0;
            end
          end
        end
        WAIT_FRAME: begin
          // The swap lands on the frame_start edge so pixel (0,0) still shows the old view.
          if (frame_start) begin
            cam_sel   <= pend_id;
            frame_cnt <= '0;
            state     <= STATIC;
            static_en <= 1'b1;
          end
        end
        STATIC: begin
          if (frame_start) begin
            if (frame_cnt == LAST_FRAME) begin
              state         <= IDLE;
              static_en     <= 1'b0;
              cam_req_ready <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + FCW'(1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          static_en     <= 1'b0;
          cam_req_ready <= 1'b1;
        end
      endcase
    end
  end

  static_lfsr u_lfsr (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .enable  (static_en),
    .q       (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:4];

`ifdef CAMERA_STATIC_FADE_EN
  logic [1:0] fade_shift;
  assign fade_shift = (int'(frame_cnt) >= 3) ? 2'd3 : 2'(frame_cnt);
  assign noise      = lfsr_q[3:0] >> fade_shift;
`else
  assign noise = lfsr_q[3:0];
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      static_level <= 4'd0;
    end else begin
      static_level <= (static_en && blank) ? noise : 4'd0;
    end
  end

endmodule

// File: tb/tb_camera_view_ctrl.sv
// tb/tb_camera_view_ctrl.sv - directed and randomized checks of camera_view_ctrl on a shrunken raster
module tb_camera_view_ctrl;

  localparam int NUM_CAMS      = 4;
  localparam int CAM_IDW       = 3;
  localparam int STATIC_FRAMES = 4;
  localparam int DEFAULT_CAM   = 0;
  // Small raster keeps whole frames cheap; only (0,0) matters to the controller.
  localparam int HT = 16;
  localparam int VT = 8;
  localparam int FL = HT * VT;

  logic               vga_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [9:0]         DrawX = '0;
  logic [9:0]         DrawY = '0;
  logic               blank = 1'b0;
  logic               cam_req_valid = 1'b0;
  logic [CAM_IDW-1:0] cam_req_id = '0;
  logic               cam_req_ready;
  logic               req_err;
  logic [1:0]         cam_sel;
  logic               static_en;
  logic [3:0]         static_level;

  camera_view_ctrl #(
    .NUM_CAMS      (NUM_CAMS),
    .CAM_IDW       (CAM_IDW),
    .STATIC_FRAMES (STATIC_FRAMES),
    .DEFAULT_CAM   (DEFAULT_CAM)
  ) dut (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .cam_req_valid (cam_req_valid),
    .cam_req_id    (cam_req_id),
    .cam_req_ready (cam_req_ready),
    .req_err       (req_err),
    .cam_sel       (cam_sel),
    .static_en     (static_en),
    .static_level  (static_level)
  );

  always #5 vga_clk = ~vga_clk;

  int vectors = 0;
  int miscompares = 0;
  int rx = 0;
  int ry = 0;
  int static_cnt = 0;
  int err_cnt = 0;

  // Reference: a pending switch plus a countdown of remaining static cycles.
  logic [1:0]  m_sel;
  logic [1:0]  m_pend_id;
  logic        m_pend;
  int          m_left;
  logic        m_ready;
  logic        m_err;
  logic [3:0]  m_level;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] noise_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_reset();
    m_sel = 2'(DEFAULT_CAM); m_pend_id = '0; m_pend = 1'b0; m_left = 0;
    m_ready = 1'b1; m_err = 1'b0; m_level = '0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_edge();
    logic       fs;
    logic       en_pre;
    int         frame;
    logic [3:0] lvl;
    if (!reset_n) begin
      model_reset();
      return;
    end
    fs     = (DrawX == 10'd0) && (DrawY == 10'd0);
    en_pre = m_left > 0;
    frame  = en_pre ? (STATIC_FRAMES * FL - m_left) / FL : 0;
    lvl    = m_lfsr[3:0];
`ifdef CAMERA_STATIC_FADE_EN
    lvl = lvl >> ((frame > 3) ? 3 : frame);
`endif
    m_level = (en_pre && blank) ? lvl : 4'd0;
    if (en_pre) m_lfsr = noise_next(m_lfsr);
    if (m_left > 0) m_left--;
    if (m_pend && fs) begin
      m_sel  = m_pend_id;
      m_left = STATIC_FRAMES * FL;
      m_pend = 1'b0;
    end
    m_err = 1'b0;
    if (m_ready && cam_req_valid) begin
      if (int'(cam_req_id) >= NUM_CAMS) m_err = 1'b1;
      else if (int'(cam_req_id) != int'(m_sel)) begin
        m_pend    = 1'b1;
        m_pend_id = 2'(cam_req_id);
      end
    end
    m_ready = !m_pend && (m_left == 0);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("cam_sel", 16'(cam_sel), 16'(m_sel));
    check("static_en", 16'(static_en), 16'(m_left > 0));
    check("cam_req_ready", 16'(cam_req_ready), 16'(m_ready));
    check("req_err", 16'(req_err), 16'(m_err));
    check("static_level", 16'(static_level), 16'(m_level));
  endtask

  task automatic step();
    model_edge();
    @(posedge vga_clk);
    #1;
    check_all();
    if (static_en === 1'b1) static_cnt++;
    if (req_err === 1'b1) err_cnt++;
    rx++;
    if (rx == HT) begin
      rx = 0;
      ry = (ry + 1) % VT;
    end
    DrawX = 10'(rx);
    DrawY = 10'(ry);
    blank = (rx < 12) && (ry < 6);
  endtask

  task automatic goto(input int x, input int y);
    for (int i = 0; i < FL && !(rx == x && ry == y); i++) step();
  endtask

  task automatic request(input int id);
    logic acc;
    acc = 1'b0;
    cam_req_valid = 1'b1;
    cam_req_id    = CAM_IDW'(id);
    for (int i = 0; i < 8 * FL && !acc; i++) begin
      acc = m_ready;
      step();
    end
    cam_req_valid = 1'b0;
    if (!acc) check("req_timeout", 16'(cam_req_ready), 16'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6 * FL && !m_ready; i++) step();
    check("idle_reached", 16'(cam_req_ready), 16'd1);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    step();

    // Normal switch with the request raised mid-frame.
    goto(10, 5);
    static_cnt = 0;
    request(2);
    wait_idle();
    check("static_len", 16'(static_cnt), 16'(STATIC_FRAMES * FL));
    check("sel_after_switch", 16'(cam_sel), 16'd2);

    // Same camera: accepted but ignored.
    static_cnt = 0;
    request(2);
    for (int i = 0; i < 2 * FL; i++) step();
    check("same_id_static", 16'(static_cnt), 16'd0);

    // Out-of-range camera.
    err_cnt = 0;
    request(5);
    for (int i = 0; i < 4; i++) step();
    check("err_pulses", 16'(err_cnt), 16'd1);
    check("sel_after_err", 16'(cam_sel), 16'd2);

    // Accepted on the frame_start cycle: must wait a full frame.
    goto(0, 0);
    request(1);
    for (int i = 0; i < FL - 1; i++) step();
    check("boundary_hold", 16'(cam_sel), 16'd2);
    step();
    check("boundary_switch", 16'(cam_sel), 16'd1);
    wait_idle();

    // Randomized requests and gaps.
    for (int n = 0; n < 6; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2 * FL));
      for (int i = 0; i < gap; i++) step();
      request(int'($urandom_range(0, 7)));
      wait_idle();
    end

    // Reset in the middle of static frame 2.
    request((int'(m_sel) + 1) % NUM_CAMS);
    for (int i = 0; i < 8 * FL && !(m_left > 0 && (STATIC_FRAMES * FL - m_left) / FL == 2 && m_left % FL == FL / 2); i++) step();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    check("reset_sel", 16'(cam_sel), 16'(DEFAULT_CAM));
    check("reset_static", 16'(static_en), 16'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    request(3);
    wait_idle();
    check("sel_after_reset_switch", 16'(cam_sel), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
